// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator.
// Turns GMII TXD/TX_EN/TX_ER plus the autoneg config word into 8b code-groups
// with a K/D flag for the downstream 8b/10b encoder. Emits /C1/C2/ config,
// /I1/I2/ idle, /S/ data /T/R/ frames and /V/, and keeps tx_even alignment.
// TXD to tx_data_8b latency is two clocks (input register + output register).
module pcs_tx_ordered_set #(
   parameter logic [1:0] XMIT_CONFIG = 2'b01,
   parameter logic [1:0] XMIT_IDLE   = 2'b10,
   parameter logic [1:0] XMIT_DATA   = 2'b11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  xmit,
   input  logic [15:0] tx_Config_Reg,
   input  logic [7:0]  TXD,
   input  logic        TX_EN,
   input  logic        TX_ER,
   input  logic        rd,
   input  logic        receiving,
   output logic [7:0]  tx_data_8b,
   output logic        tx_control,
   output logic        tx_even,
   output logic        transmitting,
   output logic        COL
);

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] D5_6  = 8'hC5;
   localparam logic [7:0] D16_2 = 8'h50;
   localparam logic [7:0] D21_5 = 8'hB5;
   localparam logic [7:0] D2_2  = 8'h42;
   localparam logic [7:0] K27_7 = 8'hFB;   // /S/
   localparam logic [7:0] K29_7 = 8'hFD;   // /T/
   localparam logic [7:0] K23_7 = 8'hF7;   // /R/
   localparam logic [7:0] K30_7 = 8'hFE;   // /V/

   // State names the code-group currently on the output registers.
   typedef enum logic [3:0] {
      ST_IDLE_K, ST_IDLE_D, ST_CFG_K, ST_CFG_D, ST_CFG_LO, ST_CFG_HI,
      ST_SOP, ST_DATA, ST_EOP_T, ST_EOP_R, ST_EOP_R2
   } state_t;

   state_t      state_q, state_d, boundary_state;
   logic [7:0]  data_q, data_d;
   logic        ctrl_q, ctrl_d;
   logic        even_q;
   logic        tx_q, tx_d;
   logic [15:0] cfg_q, cfg_d;
   logic        c2_q, c2_d;
   logic        frm_ok_q, frm_ok_d, frm_ok;
   logic [1:0]  frm_idx_q, frm_idx_d, frm_idx;
   logic [7:0]  d1_txd_q;
   logic        d1_en_q, d1_er_q, d2_en_q;
   logic        xmit_cfg, xmit_data, rise, can_start;

   // Input stage: one register on the GMII inputs, plus the previous TX_EN for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d1_txd_q <= 8'h00;
         d1_en_q  <= 1'b0;
         d1_er_q  <= 1'b0;
         d2_en_q  <= 1'b0;
      end else begin
         d1_txd_q <= TXD;
         d1_en_q  <= TX_EN;
         d1_er_q  <= TX_ER;
         d2_en_q  <= d1_en_q;
      end
   end

   // Next code-group selection: xmit decode, frame eligibility, state sequencing, output encode.
   always_comb begin
      xmit_cfg  = 1'b0;
      xmit_data = 1'b0;
      case (xmit)
         XMIT_CONFIG: xmit_cfg  = 1'b1;
         XMIT_DATA:   xmit_data = 1'b1;
         XMIT_IDLE:   xmit_cfg  = 1'b0;
         default:     xmit_cfg  = 1'b0;   // 2'b00 behaves as idle
      endcase

      // A frame is only eligible if xmit was DATA when its first byte arrived,
      // and /S/ may only replace its first or second byte (never mid-frame).
      rise      = d1_en_q & ~d2_en_q;
      frm_ok    = rise ? xmit_data : frm_ok_q;
      frm_idx   = rise ? 2'd0 : frm_idx_q;
      can_start = d1_en_q & frm_ok & xmit_data & (frm_idx <= 2'd1);
      frm_ok_d  = frm_ok;
      frm_idx_d = (d1_en_q && frm_idx != 2'd3) ? frm_idx + 2'd1 : frm_idx;

      // Ordered-set boundaries always precede an even slot, so /S/ lands even.
      if (xmit_cfg)       boundary_state = ST_CFG_K;
      else if (can_start) boundary_state = ST_SOP;
      else                boundary_state = ST_IDLE_K;

      case (state_q)
         ST_IDLE_K: state_d = ST_IDLE_D;
         ST_IDLE_D: state_d = boundary_state;
         ST_CFG_K:  state_d = ST_CFG_D;
         ST_CFG_D:  state_d = ST_CFG_LO;
         ST_CFG_LO: state_d = ST_CFG_HI;
         ST_CFG_HI: state_d = boundary_state;
         ST_SOP:    state_d = d1_en_q ? ST_DATA : ST_EOP_T;
         ST_DATA:   state_d = d1_en_q ? ST_DATA : ST_EOP_T;
         ST_EOP_T:  state_d = ST_EOP_R;
         ST_EOP_R:  state_d = even_q ? ST_EOP_R2 : boundary_state;
         ST_EOP_R2: state_d = boundary_state;
         default:   state_d = ST_IDLE_K;
      endcase

      cfg_d  = (state_d == ST_CFG_K) ? tx_Config_Reg : cfg_q;
      c2_d   = (state_d == ST_CFG_HI) ? ~c2_q : c2_q;
      tx_d   = (state_d == ST_SOP) || (state_d == ST_DATA) || (state_d == ST_EOP_T);
      data_d = K28_5;
      ctrl_d = 1'b1;
      case (state_d)
         ST_IDLE_K, ST_CFG_K: begin data_d = K28_5; ctrl_d = 1'b1; end
         ST_IDLE_D: begin data_d = rd ? D5_6 : D16_2; ctrl_d = 1'b0; end
         ST_CFG_D:  begin data_d = c2_q ? D2_2 : D21_5; ctrl_d = 1'b0; end
         ST_CFG_LO: begin data_d = cfg_q[7:0];  ctrl_d = 1'b0; end
         ST_CFG_HI: begin data_d = cfg_q[15:8]; ctrl_d = 1'b0; end
         ST_SOP:    begin data_d = K27_7; ctrl_d = 1'b1; end
         ST_DATA:   begin data_d = d1_er_q ? K30_7 : d1_txd_q; ctrl_d = d1_er_q; end
         ST_EOP_T:  begin data_d = K29_7; ctrl_d = 1'b1; end
         ST_EOP_R, ST_EOP_R2: begin data_d = K23_7; ctrl_d = 1'b1; end
         default:   begin data_d = K28_5; ctrl_d = 1'b1; end
      endcase
   end

   // Ordered-set FSM with registered outputs; the reset slot acts as the K of an
   // idle set, so the first clocked code-group is the odd /D/ that completes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE_K;
         data_q    <= K28_5;
         ctrl_q    <= 1'b1;
         even_q    <= 1'b1;
         tx_q      <= 1'b0;
         cfg_q     <= 16'h0000;
         c2_q      <= 1'b0;
         frm_ok_q  <= 1'b0;
         frm_idx_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         ctrl_q    <= ctrl_d;
         even_q    <= ~even_q;
         tx_q      <= tx_d;
         cfg_q     <= cfg_d;
         c2_q      <= c2_d;
         frm_ok_q  <= frm_ok_d;
         frm_idx_q <= frm_idx_d;
      end
   end

   assign tx_data_8b   = data_q;
   assign tx_control   = ctrl_q;
   assign tx_even      = even_q;
   assign transmitting = tx_q;
   assign COL          = tx_q & receiving;

endmodule
